bsg_cover_mc: RTL and testbench

Multi-channel coverage collector, one clock domain. Each channel deduplicates incoming coverage words into its own CAM and keeps a saturating hit count per unique word. A channel drains when its CAM fills or when drain is requested. Draining channels share one output stream under a round-robin arbiter, and each drain is framed by a header beat.

---
 rtl/bsg_cover_mc_pkg.sv | 29 ++
 rtl/bsg_cover_mc_chan.sv | 151 +++++++++++++++
 rtl/bsg_cover_mc.sv | 113 +++++++++++
 tb/tb_bsg_cover_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cover_mc_pkg.sv
// Shared types for the multi-channel coverage collector: channel states,
// the output beat record and a configuration sanity check.
package bsg_cover_mc_pkg;

    // Widest word / counter a beat can carry; instances narrow these fields.
    localparam int max_width_lp       = 64;
    localparam int max_count_width_lp = 32;

    typedef enum logic [1:0] {
        CHAN_FILL  = 2'd0,
        CHAN_WAIT  = 2'd1,
        CHAN_HDR   = 2'd2,
        CHAN_DRAIN = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic                          hdr_v;
        logic [max_width_lp-1:0]       data;
        logic [max_count_width_lp-1:0] count;
    } beat_t;

    // The hit counter must also be able to hold the header entry count (0..els).
    function automatic bit cfg_ok(input int els, input int width, input int count_width);
        return (els >= 1) && (width >= 1) && (width <= max_width_lp) &&
               (count_width <= max_count_width_lp) &&
               (count_width >= $clog2(els + 1));
    endfunction

endpackage

// File: rtl/bsg_cover_mc_chan.sv
// One coverage channel: a small CAM of unique words with saturating hit
// counts, plus the FILL/WAIT/HDR/DRAIN sequencer that frames its drain.
module bsg_cover_mc_chan
    import bsg_cover_mc_pkg::*;
#(
    parameter int width_p       = 16,
    parameter int els_p         = 8,
    parameter int count_width_p = 8,
    parameter int idx_p         = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               drain_i,
    input  logic               grant_i,
    input  logic               yumi_i,
    output logic               ready_o,
    output logic               gate_o,
    output logic               req_o,
    output logic               active_o,
    output logic               done_o,
    output beat_t              beat_o
);

    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    chan_state_e              state_q, state_d;
    logic [els_p-1:0]         valid_q, valid_d;
    logic [width_p-1:0]       tag_q [els_p];
    logic [width_p-1:0]       tag_d [els_p];
    logic [count_width_p-1:0] cnt_q [els_p];
    logic [count_width_p-1:0] cnt_d [els_p];

    logic [els_p-1:0]         hit_s;
    logic                     hit_any_s;
    logic                     free_any_s;
    logic [idx_w_lp-1:0]      hit_idx_s;
    logic [idx_w_lp-1:0]      free_idx_s;
    logic [idx_w_lp-1:0]      head_idx_s;
    logic [count_width_p-1:0] num_valid_s;
    beat_t                    beat_s;

    // Compare the incoming word against every occupied entry.
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            hit_s[i] = valid_q[i] && (tag_q[i] == data_i);
        end
    end

    assign hit_any_s  = |hit_s;
    assign free_any_s = ~(&valid_q);

    // Lowest-index encoders for hit, free slot and drain head, plus occupancy count.
    always_comb begin
        hit_idx_s   = '0;
        free_idx_s  = '0;
        head_idx_s  = '0;
        num_valid_s = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            hit_idx_s  = hit_s[i]    ? idx_w_lp'(i) : hit_idx_s;
            free_idx_s = !valid_q[i] ? idx_w_lp'(i) : free_idx_s;
            head_idx_s = valid_q[i]  ? idx_w_lp'(i) : head_idx_s;
        end
        for (int i = 0; i < els_p; i++) begin
            num_valid_s = num_valid_s + count_width_p'(valid_q[i]);
        end
    end

    // Next-state, CAM update and current output beat.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        beat_s  = '0;
        case (state_q)
            CHAN_FILL: begin
                if (v_i) begin
                    if (hit_any_s) begin
                        cnt_d[hit_idx_s] = (cnt_q[hit_idx_s] == '1) ? cnt_q[hit_idx_s]
                                         : cnt_q[hit_idx_s] + count_width_p'(1);
                    end else if (free_any_s) begin
                        valid_d[free_idx_s] = 1'b1;
                        tag_d[free_idx_s]   = data_i;
                        cnt_d[free_idx_s]   = count_width_p'(1);
                    end else begin
                        valid_d = valid_q;
                    end
                end else begin
                    valid_d = valid_q;
                end
                // Input of this cycle is recorded above before leaving FILL.
                state_d = (drain_i || (&valid_d)) ? CHAN_WAIT : CHAN_FILL;
            end
            CHAN_WAIT: begin
                state_d = grant_i ? CHAN_HDR : CHAN_WAIT;
            end
            CHAN_HDR: begin
                beat_s.hdr_v                      = 1'b1;
                beat_s.data[width_p-1:0]          = width_p'(idx_p);
                beat_s.count[count_width_p-1:0]   = num_valid_s;
                if (yumi_i) begin
                    state_d = (num_valid_s == '0) ? CHAN_FILL : CHAN_DRAIN;
                end else begin
                    state_d = CHAN_HDR;
                end
            end
            CHAN_DRAIN: begin
                beat_s.data[width_p-1:0]        = tag_q[head_idx_s];
                beat_s.count[count_width_p-1:0] = cnt_q[head_idx_s];
                if (yumi_i) begin
                    valid_d[head_idx_s] = 1'b0;
                    state_d = (num_valid_s == count_width_p'(1)) ? CHAN_FILL : CHAN_DRAIN;
                end else begin
                    state_d = CHAN_DRAIN;
                end
            end
            default: begin
                state_d = CHAN_FILL;
            end
        endcase
    end

    // State and CAM registers; reset abandons any packet in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= CHAN_FILL;
            valid_q <= '0;
            for (int i = 0; i < els_p; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            for (int i = 0; i < els_p; i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ready_o  = (state_q == CHAN_FILL);
    assign gate_o   = (state_q != CHAN_FILL);
    assign req_o    = (state_q == CHAN_WAIT);
    assign active_o = (state_q == CHAN_HDR) || (state_q == CHAN_DRAIN);
    assign done_o   = active_o && (state_d == CHAN_FILL);
    assign beat_o   = beat_s;

endmodule

// File: rtl/bsg_cover_mc.sv
// Multi-channel coverage collector top: per-channel CAMs sharing one framed
// output stream through a round-robin arbiter.
module bsg_cover_mc
    import bsg_cover_mc_pkg::*;
#(
    parameter int num_chan_p    = 2,
    parameter int width_p       = 16,
    parameter int els_p         = 8,
    parameter int count_width_p = 8,
    parameter int base_idx_p    = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_chan_p-1:0]         v_i,
    input  logic [num_chan_p*width_p-1:0] data_i,
    output logic [num_chan_p-1:0]         ready_o,
    input  logic [num_chan_p-1:0]         drain_i,
    output logic [num_chan_p-1:0]         gate_o,
    output logic                          v_o,
    output logic                          hdr_v_o,
    output logic [width_p-1:0]            data_o,
    output logic [count_width_p-1:0]      count_o,
    input  logic                          ready_i
);

    localparam int ptr_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

    if (!cfg_ok(els_p, width_p, count_width_p)) begin : g_bad_cfg
        $error("bsg_cover_mc: unsupported width_p/els_p/count_width_p combination");
    end

    logic [num_chan_p-1:0] req_s;
    logic [num_chan_p-1:0] active_s;
    logic [num_chan_p-1:0] done_s;
    logic [num_chan_p-1:0] grant_s;
    beat_t                 beats_s [num_chan_p];
    beat_t                 sel_beat_s;
    logic [ptr_w_lp-1:0]   ptr_q, ptr_d;
    logic                  unused_beat_s;

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        bsg_cover_mc_chan #(
            .width_p       (width_p),
            .els_p         (els_p),
            .count_width_p (count_width_p),
            .idx_p         (base_idx_p + c)
        ) u_chan (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .v_i       (v_i[c]),
            .data_i    (data_i[c*width_p +: width_p]),
            .drain_i   (drain_i[c]),
            .grant_i   (grant_s[c]),
            .yumi_i    (active_s[c] & ready_i),
            .ready_o   (ready_o[c]),
            .gate_o    (gate_o[c]),
            .req_o     (req_s[c]),
            .active_o  (active_s[c]),
            .done_o    (done_s[c]),
            .beat_o    (beats_s[c])
        );
    end

    // Grant the first waiting channel at or after the pointer, only when the stream is idle.
    always_comb begin : arb_comb
        logic [ptr_w_lp-1:0] cand;
        logic                taken;
        grant_s = '0;
        taken   = 1'b0;
        cand    = '0;
        for (int k = 0; k < num_chan_p; k++) begin
            cand = ptr_w_lp'((int'(ptr_q) + k) % num_chan_p);
            if (!taken && !(|active_s) && req_s[cand]) begin
                grant_s[cand] = 1'b1;
                taken         = 1'b1;
            end else begin
                taken = taken;
            end
        end
    end

    // Pointer advances past a channel when its packet completes.
    always_comb begin
        ptr_d = ptr_q;
        for (int c = 0; c < num_chan_p; c++) begin
            ptr_d = done_s[c] ? ptr_w_lp'((c + 1) % num_chan_p) : ptr_d;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Select the beat of the single channel currently in HDR or DRAIN.
    always_comb begin
        sel_beat_s = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            sel_beat_s = active_s[c] ? beats_s[c] : sel_beat_s;
        end
    end

    assign v_o           = |active_s;
    assign hdr_v_o       = sel_beat_s.hdr_v;
    assign data_o        = sel_beat_s.data[width_p-1:0];
    assign count_o       = sel_beat_s.count[count_width_p-1:0];
    assign unused_beat_s = ^sel_beat_s;

endmodule

// File: tb/tb_bsg_cover_mc.sv
// Directed bench for bsg_cover_mc: a vector table for the basic fill/drain
// packet plus hand-written sequences for the multi-cycle corners.
module tb_bsg_cover_mc;

    localparam int nc_lp   = 2;
    localparam int w_lp    = 16;
    localparam int els_lp  = 4;
    localparam int cw_lp   = 4;
    localparam int base_lp = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        v_i;
    logic [31:0]       data_i;
    logic [1:0]        ready_o;
    logic [1:0]        drain_i;
    logic [1:0]        gate_o;
    logic              v_o;
    logic              hdr_v_o;
    logic [15:0]       data_o;
    logic [3:0]        count_o;
    logic              ready_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d0;
        logic [1:0]  drain;
        logic        rdy;
        logic        ev;
        logic        eh;
        logic [15:0] ed;
        logic [3:0]  ec;
        logic [1:0]  er;
        logic [1:0]  eg;
    } vec_t;

    vec_t        vec [12];
    logic [20:0] cap_q [$];
    int          cap_t [$];
    logic [20:0] exp_q [$];

    always #5 clk = ~clk;

    bsg_cover_mc #(
        .num_chan_p    (nc_lp),
        .width_p       (w_lp),
        .els_p         (els_lp),
        .count_width_p (cw_lp),
        .base_idx_p    (base_lp)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .drain_i   (drain_i),
        .gate_o    (gate_o),
        .v_o       (v_o),
        .hdr_v_o   (hdr_v_o),
        .data_o    (data_o),
        .count_o   (count_o),
        .ready_i   (ready_i)
    );

    function automatic vec_t mk(input logic [1:0] v, input logic [15:0] d0, input logic [1:0] dr,
                                input logic ev, input logic eh, input logic [15:0] ed,
                                input logic [3:0] ec, input logic [1:0] er, input logic [1:0] eg);
        vec_t r;
        r.v = v; r.d0 = d0; r.drain = dr; r.rdy = 1'b1;
        r.ev = ev; r.eh = eh; r.ed = ed; r.ec = ec; r.er = er; r.eg = eg;
        return r;
    endfunction

    function automatic logic [20:0] bt(input logic h, input logic [15:0] d, input logic [3:0] c);
        return {h, d, c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles with ready_i as set, logging every handshaken beat and its cycle.
    task automatic capture(input int n);
        cap_q.delete();
        cap_t.delete();
        for (int i = 0; i < n; i++) begin
            #1;
            if (v_o && ready_i) begin
                cap_q.push_back({hdr_v_o, data_o, count_o});
                cap_t.push_back(i);
            end
            cyc();
        end
    endtask

    task automatic compare_caps(input string name);
        check({name, ".nbeats"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) begin
                check($sformatf("%s.beat%0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
            end
        end
    endtask

    task automatic expect_beat(input string name, input logic h, input logic [15:0] d, input logic [3:0] c);
        check(name, {v_o, hdr_v_o, data_o, count_o}, {1'b1, h, d, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic packet: 0x11,0x22,0x11,0x33,0x44 into ch0, ready_i=1 throughout.
        vec[0]  = mk(2'b01, 16'h0011, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);
        vec[1]  = mk(2'b01, 16'h0022, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);
        vec[2]  = mk(2'b01, 16'h0011, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);
        vec[3]  = mk(2'b01, 16'h0033, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);
        vec[4]  = mk(2'b01, 16'h0044, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);
        vec[5]  = mk(2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b10, 2'b01);
        vec[6]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0008, 4'd4, 2'b10, 2'b01);
        vec[7]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0011, 4'd2, 2'b10, 2'b01);
        vec[8]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0022, 4'd1, 2'b10, 2'b01);
        vec[9]  = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0033, 4'd1, 2'b10, 2'b01);
        vec[10] = mk(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0044, 4'd1, 2'b10, 2'b01);
        vec[11] = mk(2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 4'd0, 2'b11, 2'b00);

        reset_n = 1'b0;
        v_i     = 2'b00;
        data_i  = 32'h0;
        drain_i = 2'b00;
        ready_i = 1'b1;
        #12;
        check("reset.v_o", 64'(v_o), 64'(1'b0));
        check("reset.hdr_v_o", 64'(hdr_v_o), 64'(1'b0));
        check("reset.gate_o", 64'(gate_o), 64'(2'b00));
        check("reset.ready_o", 64'(ready_o), 64'(2'b11));
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            v_i     = vec[i].v;
            data_i  = {16'h0000, vec[i].d0};
            drain_i = vec[i].drain;
            ready_i = vec[i].rdy;
            #1;
            if (vec[i].ev) begin
                check($sformatf("vec%0d", i), {v_o, hdr_v_o, data_o, count_o, ready_o, gate_o},
                      {vec[i].ev, vec[i].eh, vec[i].ed, vec[i].ec, vec[i].er, vec[i].eg});
            end else begin
                check($sformatf("vec%0d", i), {v_o, hdr_v_o, ready_o, gate_o},
                      {vec[i].ev, vec[i].eh, vec[i].er, vec[i].eg});
            end
            cyc();
        end

        // Empty drain on ch0: header with count 0 only.
        drain_i = 2'b01;
        cyc();
        drain_i = 2'b00;
        capture(5);
        exp_q.delete();
        exp_q.push_back(bt(1'b1, 16'h0008, 4'd0));
        compare_caps("empty");
        #1;
        check("empty.ready_o", 64'(ready_o), 64'(2'b11));

        // Ch1 saturation: 20 copies of 0x5A then a drain pulse.
        for (int i = 0; i < 20; i++) begin
            v_i    = 2'b10;
            data_i = {16'h005A, 16'h0000};
            cyc();
        end
        v_i     = 2'b00;
        drain_i = 2'b10;
        cyc();
        drain_i = 2'b00;
        capture(6);
        exp_q.delete();
        exp_q.push_back(bt(1'b1, 16'h0009, 4'd1));
        exp_q.push_back(bt(1'b0, 16'h005A, 4'd15));
        compare_caps("sat");

        // Both channels fill together: ch0 first, one idle cycle, then ch1.
        for (int i = 0; i < 4; i++) begin
            v_i    = 2'b11;
            data_i = {16'h00A0 + 16'(i), 16'h0001 + 16'(i)};
            cyc();
        end
        v_i = 2'b00;
        capture(16);
        exp_q.delete();
        exp_q.push_back(bt(1'b1, 16'h0008, 4'd4));
        for (int i = 0; i < 4; i++) exp_q.push_back(bt(1'b0, 16'h0001 + 16'(i), 4'd1));
        exp_q.push_back(bt(1'b1, 16'h0009, 4'd4));
        for (int i = 0; i < 4; i++) exp_q.push_back(bt(1'b0, 16'h00A0 + 16'(i), 4'd1));
        compare_caps("rr");
        if (cap_t.size() >= 6) begin
            check("rr.gap", 64'(cap_t[5] - cap_t[4]), 64'(2));
        end
        drain_i = 2'b11;
        cyc();
        drain_i = 2'b00;
        capture(8);
        exp_q.delete();
        exp_q.push_back(bt(1'b1, 16'h0008, 4'd0));
        exp_q.push_back(bt(1'b1, 16'h0009, 4'd0));
        compare_caps("rr2");

        // Backpressure during HDR/DRAIN; last word accepted together with drain.
        v_i = 2'b01; data_i = 32'h0000_0100; cyc();
        data_i = 32'h0000_0200; cyc();
        data_i = 32'h0000_0300; drain_i = 2'b01; cyc();
        v_i = 2'b00; drain_i = 2'b00;
        #1;
        check("stall.wait", {v_o, ready_o, gate_o}, {1'b0, 2'b10, 2'b01});
        cyc();
        ready_i = 1'b0;
        #1; expect_beat("stall.hdr", 1'b1, 16'h0008, 4'd3);
        cyc();
        expect_beat("stall.hdr_hold", 1'b1, 16'h0008, 4'd3);
        ready_i = 1'b1;
        #1; expect_beat("stall.hdr_go", 1'b1, 16'h0008, 4'd3);
        cyc();
        for (int k = 0; k < 3; k++) begin
            ready_i = 1'b0;
            #1; expect_beat($sformatf("stall.body%0d", k), 1'b0, 16'(k + 1) << 8, 4'd1);
            cyc();
            expect_beat($sformatf("stall.body%0d_hold", k), 1'b0, 16'(k + 1) << 8, 4'd1);
            ready_i = 1'b1;
            #1; expect_beat($sformatf("stall.body%0d_go", k), 1'b0, 16'(k + 1) << 8, 4'd1);
            cyc();
        end
        check("stall.end", {v_o, ready_o, gate_o}, {1'b0, 2'b11, 2'b00});

        // Asynchronous reset in the middle of a ch1 drain.
        v_i = 2'b10; data_i = 32'h0007_0000; cyc();
        data_i = 32'h0008_0000; cyc();
        v_i = 2'b00; drain_i = 2'b10; cyc();
        drain_i = 2'b00; cyc();
        #1; expect_beat("arst.hdr", 1'b1, 16'h0009, 4'd2);
        cyc();
        ready_i = 1'b0;
        #1; expect_beat("arst.body", 1'b0, 16'h0007, 4'd1);
        #1; reset_n = 1'b0;
        #1;
        check("arst.v_o", 64'(v_o), 64'(1'b0));
        check("arst.ready_gate", {ready_o, gate_o}, {2'b11, 2'b00});
        #1; reset_n = 1'b1;
        cyc();
        ready_i = 1'b1;
        #1;
        check("arst.after", {v_o, ready_o, gate_o}, {1'b0, 2'b11, 2'b00});
        drain_i = 2'b10;
        cyc();
        drain_i = 2'b00;
        capture(5);
        exp_q.delete();
        exp_q.push_back(bt(1'b1, 16'h0009, 4'd0));
        compare_caps("arst.redrain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
